// File: rtl/xbar_pipe_if.sv
// Crossbar output slice bus: upstream flit/select/valid/ready plus downstream flit/valid/ready and error status.
// slave = slice side, master = driver side (allocator/input FIFOs and output link register).
interface xbar_pipe_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_PORTS     = 5,
   parameter int ERR_CNT_WIDTH = 8
);
   logic [NUM_PORTS*DATA_WIDTH-1:0] data_in;
   logic [NUM_PORTS-1:0]            sel;
   logic                            valid_in;
   logic                            ready_out;
   logic [DATA_WIDTH-1:0]           data_out;
   logic                            valid_out;
   logic                            ready_in;
   logic                            sel_err;
   logic [ERR_CNT_WIDTH-1:0]        err_count;

   modport slave (
      input  data_in, sel, valid_in, ready_in,
      output ready_out, data_out, valid_out, sel_err, err_count
   );

   modport master (
      output data_in, sel, valid_in, ready_in,
      input  ready_out, data_out, valid_out, sel_err, err_count
   );
endinterface

// File: rtl/xbar_pipe.sv
// Crossbar output slice: one-hot mux into a 2-entry skid buffer; accept->valid_out 1 cycle, ready_out = ~skid_valid (registered).
// XBAR_SEL_CHECK_EN: illegal selects are consumed and dropped, pulsing sel_err and bumping a saturating err_count.
module xbar_pipe #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_PORTS     = 5,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   xbar_pipe_if.slave  bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] main_q, main_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic [DATA_WIDTH-1:0] flit_sel;
   logic                  sel_legal;
   logic                  accept;
   logic                  drain;
   logic                  store;

   // Lowest set index wins; an all-zero select falls back to the last port (North).
   always_comb begin
      flit_sel = bus.data_in[(NUM_PORTS-1)*DATA_WIDTH +: DATA_WIDTH];
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (bus.sel[i]) begin
            flit_sel = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign bus.ready_out = (state_q != FULL);
   assign bus.valid_out = (state_q != EMPTY);
   assign bus.data_out  = main_q;

   assign accept = bus.valid_in & bus.ready_out;
   assign drain  = bus.valid_out & bus.ready_in;
   assign store  = accept & sel_legal;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (store) begin
               main_d  = flit_sel;
               state_d = ONE;
            end
         end
         ONE: begin
            if (store && drain) begin
               main_d = flit_sel;
            end else if (store) begin
               skid_d  = flit_sel;
               state_d = FULL;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (drain) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef XBAR_SEL_CHECK_EN
   logic [NUM_PORTS-1:0]     sel_m1;
   logic                     sel_err_q, sel_err_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   // A value is one-hot when it is non-zero and clearing its lowest set bit leaves nothing.
   assign sel_m1    = bus.sel - NUM_PORTS'(1);
   assign sel_legal = (bus.sel != '0) && ((bus.sel & sel_m1) == '0);

   always_comb begin
      sel_err_d = accept & ~sel_legal;
      err_cnt_d = err_cnt_q;
      if (sel_err_d && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         sel_err_q <= sel_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.sel_err   = sel_err_q;
   assign bus.err_count = err_cnt_q;
`else
   assign sel_legal     = 1'b1;
   assign bus.sel_err   = 1'b0;
   assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_xbar_pipe.sv
// Scoreboard bench for xbar_pipe: randomized and directed flits checked against a queue-based occupancy model.
module tb_xbar_pipe;
   localparam int DW  = 32;
   localparam int NP  = 5;
   localparam int ECW = 2;

   logic clk = 1'b0;
   logic reset;

   xbar_pipe_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .ERR_CNT_WIDTH(ECW)) bus ();

   xbar_pipe #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .ERR_CNT_WIDTH(ECW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Flits accepted and not yet drained, oldest first; its size is the buffer occupancy.
   logic [DW-1:0] exp_q[$];
   logic          pend_vld = 1'b0;
   logic          pend_legal = 1'b0;
   logic [DW-1:0] pend_dat = '0;
   logic          exp_err = 1'b0;
   int            exp_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [NP*DW-1:0] rand_bus();
      logic [NP*DW-1:0] r;
      for (int i = 0; i < NP; i++) r[i*DW +: DW] = $urandom;
      return r;
   endfunction

   function automatic void model_flit(input logic [NP-1:0] s, input logic [NP*DW-1:0] d,
                                      output logic legal, output logic [DW-1:0] f);
      int idx;
`ifdef XBAR_SEL_CHECK_EN
      legal = ($countones(s) == 1);
`else
      legal = 1'b1;
`endif
      idx = -1;
      for (int i = 0; i < NP; i++) begin
         if (s[i] && idx < 0) idx = i;
      end
      if (idx < 0) idx = NP - 1;
      f = d[idx*DW +: DW];
   endfunction

   // Called at posedge+1; drives one cycle and hands the expected outcome to the scoreboard.
   task automatic cycle(input logic v, input logic [NP-1:0] s, input logic [NP*DW-1:0] d, output logic acc);
      logic          lg;
      logic [DW-1:0] f;
      bus.valid_in = v;
      bus.sel      = s;
      bus.data_in  = d;
      acc = v && (exp_q.size() < 2);
      if (acc) begin
         model_flit(s, d, lg, f);
         pend_legal = lg;
         pend_dat   = f;
         pend_vld   = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [NP-1:0] s, input logic [NP*DW-1:0] d);
      logic acc;
      int   n;
      n = 0;
      do begin
         cycle(1'b1, s, d, acc);
         n++;
      end while (!acc && n < 50);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: flit not accepted within 50 cycles, sel=%b", s);
      end
      bus.valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, NP'($urandom), rand_bus(), acc);
   endtask

   // Monitor: compare what the DUT presents now, then advance the model across the coming edge.
   always @(negedge clk) begin
      if (reset) begin
         check("valid_out", 64'(bus.valid_out), 64'(exp_q.size() > 0));
         check("ready_out", 64'(bus.ready_out), 64'(exp_q.size() < 2));
         if (exp_q.size() > 0) check("data_out", 64'(bus.data_out), 64'(exp_q[0]));
         check("sel_err", 64'(bus.sel_err), 64'(exp_err));
         check("err_count", 64'(bus.err_count), 64'(exp_cnt));
         exp_err = 1'b0;
         if (exp_q.size() > 0 && bus.ready_in) void'(exp_q.pop_front());
         if (pend_vld) begin
            if (pend_legal) begin
               exp_q.push_back(pend_dat);
            end else begin
               exp_err = 1'b1;
               if (exp_cnt < (1 << ECW) - 1) exp_cnt++;
            end
            pend_vld = 1'b0;
         end
      end
   end

   initial begin
      logic [NP*DW-1:0] d;
      logic [NP-1:0]    s;
      logic             acc;

      reset        = 1'b0;
      bus.valid_in = 1'b0;
      bus.sel      = '0;
      bus.data_in  = '0;
      bus.ready_in = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_valid_out", 64'(bus.valid_out), 64'd0);
      check("rst_data_out", 64'(bus.data_out), 64'd0);
      check("rst_ready_out", 64'(bus.ready_out), 64'd1);
      check("rst_sel_err", 64'(bus.sel_err), 64'd0);
      check("rst_err_count", 64'(bus.err_count), 64'd0);
      reset = 1'b1;
      idle(2);

      // Single flit from South.
      bus.ready_in = 1'b1;
      d = rand_bus();
      d[1*DW +: DW] = 32'hA5A5_A5A5;
      send(5'b00010, d);
      idle(3);

      // Streaming: 8 back-to-back flits per port.
      for (int p = 0; p < NP; p++) begin
         for (int k = 0; k < 8; k++) begin
            cycle(1'b1, NP'(1 << p), rand_bus(), acc);
            check("stream_accept", 64'(acc), 64'd1);
         end
      end
      bus.valid_in = 1'b0;
      idle(3);

      // Backpressure: two flits fill the buffer, the third waits for release.
      bus.ready_in = 1'b0;
      fork
         begin
            send(5'b00100, rand_bus());
            send(5'b01000, rand_bus());
            send(5'b10000, rand_bus());
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            check("bp_ready_low", 64'(bus.ready_out), 64'd0);
            check("bp_valid_held", 64'(bus.valid_out), 64'd1);
            bus.ready_in = 1'b1;
         end
      join
      idle(4);

      // Illegal selects: zero and multi-hot, then enough zeros to saturate the counter.
      d = rand_bus();
      d[4*DW +: DW] = 32'h0000_0011;
      send(5'b00000, d);
      send(5'b00110, rand_bus());
      idle(3);
      for (int k = 0; k < 5; k++) send(5'b00000, rand_bus());
      idle(3);
`ifdef XBAR_SEL_CHECK_EN
      check("err_count_sat", 64'(bus.err_count), 64'd3);
`else
      check("err_count_tied", 64'(bus.err_count), 64'd0);
`endif

      // Randomized traffic with random backpressure and occasional illegal selects.
      for (int k = 0; k < 400; k++) begin
         bus.ready_in = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 7) == 0) s = NP'($urandom);
         else s = NP'(1 << $urandom_range(0, NP - 1));
         cycle($urandom_range(0, 3) != 0, s, rand_bus(), acc);
      end
      bus.valid_in = 1'b0;
      bus.ready_in = 1'b1;
      idle(4);

      // Reset while both entries are occupied.
      bus.ready_in = 1'b0;
      send(5'b00001, rand_bus());
      send(5'b00010, rand_bus());
      check("full_ready_low", 64'(bus.ready_out), 64'd0);
      #2;
      reset    = 1'b0;
      pend_vld = 1'b0;
      exp_q.delete();
      exp_err  = 1'b0;
      exp_cnt  = 0;
      #1;
      check("midrst_valid_out", 64'(bus.valid_out), 64'd0);
      check("midrst_ready_out", 64'(bus.ready_out), 64'd1);
      check("midrst_data_out", 64'(bus.data_out), 64'd0);
      check("midrst_err_count", 64'(bus.err_count), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.ready_in = 1'b1;
      idle(5);
      check("post_rst_no_stale", 64'(bus.valid_out), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
